// File: rtl/ps2_key_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_rx_if
//  Description : Pin/event bundle between the PS/2 connector side and the
//                key receiver. The master drives the PS/2 pins and consumes
//                the key event word; the slave is the receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_key_rx_if;
  logic        I_PS2_CLK;
  logic        I_PS2_DAT;
  logic [10:0] O_PS2_KEY;
  logic        O_ERR;

  modport master (
    output I_PS2_CLK,
    output I_PS2_DAT,
    input  O_PS2_KEY,
    input  O_ERR
  );

  modport slave (
    input  I_PS2_CLK,
    input  I_PS2_DAT,
    output O_PS2_KEY,
    output O_ERR
  );
endinterface
`default_nettype wire

// File: rtl/ps2_key_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_rx
//  Description : PS/2 keyboard receiver. Synchronises and filters the pins,
//                deserialises 11-bit frames, resolves E0/F0 prefixes, drops
//                the E1 Pause sequence and emits an 11-bit key event word
//                {toggle, pressed, extended, scancode}.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_rx #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 49152
) (
  input  wire logic  I_CLK,
  input  wire logic  I_RESETn,
  ps2_key_rx_if.slave bus
);

  localparam int FCW = $clog2(FILT_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Input conditioning
  logic           r_clk_s1, r_clk_s2;
  logic           r_dat_s1, r_dat_s2;
  logic           r_filt_clk, r_filt_prev;
  logic [FCW-1:0] r_filt_cnt;
  logic           w_fall;

  // Frame FSM
  state_t         r_state, w_state_nxt;
  logic [7:0]     r_shift, w_shift_nxt;
  logic [2:0]     r_bitcnt, w_bitcnt_nxt;
  logic           r_par, w_par_nxt;
  logic           w_vld_nxt, w_err_nxt;
  logic [TCW-1:0] r_to_cnt;
  logic           w_timeout;

  // Byte hand-off and decoder
  logic           r_vld;
  logic           r_err;
  logic [7:0]     r_byte;
  logic [10:0]    r_key;
  logic           r_ext, r_rel;
  logic [2:0]     r_skip;

  // Two-flop synchronisers for both asynchronous pins
  always_ff @(posedge I_CLK or negedge I_RESETn) begin
    if (!I_RESETn) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= bus.I_PS2_CLK;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= bus.I_PS2_DAT;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Accept a clock level change only after it has held for FILT_LEN cycles
  always_ff @(posedge I_CLK or negedge I_RESETn) begin
    if (!I_RESETn) begin
      r_filt_clk  <= 1'b1;
      r_filt_prev <= 1'b1;
      r_filt_cnt  <= '0;
    end else begin
      r_filt_prev <= r_filt_clk;
      if (r_clk_s2 == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FCW'(FILT_LEN - 1)) begin
        r_filt_clk <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FCW'(1);
      end
    end
  end

  assign w_fall = r_filt_prev & ~r_filt_clk;

  // Mid-frame watchdog: cleared by every falling edge, idle in IDLE
  assign w_timeout = (r_state != S_IDLE) && !w_fall &&
                     (r_to_cnt == TCW'(TIMEOUT_CYC - 1));

  always_ff @(posedge I_CLK or negedge I_RESETn) begin
    if (!I_RESETn) begin
      r_to_cnt <= '0;
    end else if (r_state == S_IDLE || w_fall || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TCW'(1);
    end
  end

  // Frame FSM state register
  always_ff @(posedge I_CLK or negedge I_RESETn) begin
    if (!I_RESETn) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_par    <= 1'b0;
      r_vld    <= 1'b0;
      r_err    <= 1'b0;
      r_byte   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_par    <= w_par_nxt;
      r_vld    <= w_vld_nxt;
      r_err    <= w_err_nxt;
      if (w_vld_nxt) begin
        r_byte <= r_shift;
      end
    end
  end

  // Frame FSM next state: advances only on filtered falling edges
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_par_nxt    = r_par;
    w_vld_nxt    = 1'b0;
    w_err_nxt    = 1'b0;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_err_nxt   = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE: begin
          // A high level here is a glitch, not a start bit
          if (!r_dat_s2) begin
            w_state_nxt  = S_DATA;
            w_bitcnt_nxt = 3'd0;
          end
        end
        S_DATA: begin
          w_shift_nxt  = {r_dat_s2, r_shift[7:1]};
          w_bitcnt_nxt = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            w_state_nxt = S_PARITY;
          end
        end
        S_PARITY: begin
          w_par_nxt   = r_dat_s2;
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          if (r_dat_s2 && (^{r_shift, r_par})) begin
            w_vld_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Prefix resolution and key event generation; errors flush prefix state
  always_ff @(posedge I_CLK or negedge I_RESETn) begin
    if (!I_RESETn) begin
      r_key  <= '0;
      r_ext  <= 1'b0;
      r_rel  <= 1'b0;
      r_skip <= '0;
    end else if (r_err) begin
      r_ext  <= 1'b0;
      r_rel  <= 1'b0;
      r_skip <= '0;
    end else if (r_vld) begin
      if (r_skip != 3'd0) begin
        r_skip <= r_skip - 3'd1;
      end else if (r_byte == 8'hE1) begin
        // Pause: E1 plus seven following bytes carry no key event
        r_skip <= 3'd7;
        r_ext  <= 1'b0;
        r_rel  <= 1'b0;
      end else if (r_byte == 8'hE0) begin
        r_ext <= 1'b1;
      end else if (r_byte == 8'hF0) begin
        r_rel <= 1'b1;
      end else begin
        r_key <= {~r_key[10], ~r_rel, r_ext, r_byte};
        r_ext <= 1'b0;
        r_rel <= 1'b0;
      end
    end
  end

  assign bus.O_PS2_KEY = r_key;
  assign bus.O_ERR     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_rx
//  Description : Directed self-checking bench for ps2_key_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_rx;

  localparam int TO_CYC = 2000;
  localparam int H      = 20;   // PS/2 half bit period in system cycles

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  int   err_cnt;
  int   upd_cnt;
  logic [10:0] prev_key;

  ps2_key_rx_if bus ();

  ps2_key_rx #(
    .FILT_LEN   (8),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .I_CLK   (clk),
    .I_RESETn(rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count error pulses and key word changes, sampled away from the active edge
  initial begin
    err_cnt  = 0;
    upd_cnt  = 0;
    prev_key = 11'h000;
  end
  always @(negedge clk) begin
    if (bus.O_ERR === 1'b1) err_cnt = err_cnt + 1;
    if (bus.O_PS2_KEY !== prev_key) upd_cnt = upd_cnt + 1;
    prev_key = bus.O_PS2_KEY;
  end

  task automatic ps2_bit(input logic b);
    bus.I_PS2_DAT = b;
    repeat (H) @(posedge clk);
    bus.I_PS2_CLK = 1'b0;
    repeat (H) @(posedge clk);
    bus.I_PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ par_flip);
    ps2_bit(stop);
    bus.I_PS2_DAT = 1'b1;
    repeat (2 * H) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.I_PS2_CLK = 1'b1;
    bus.I_PS2_DAT = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_total++;
    if (bus.O_PS2_KEY !== 11'h000) $display("FAIL reset_key actual=%h required=%h", bus.O_PS2_KEY, 11'h000);
    else n_pass++;
    n_total++;
    if (bus.O_ERR !== 1'b0) $display("FAIL reset_err actual=%b required=0", bus.O_ERR);
    else n_pass++;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_make();
    int e0;
    e0 = err_cnt;
    send_byte(8'h1C);
    n_total++;
    if (bus.O_PS2_KEY !== 11'h61C) $display("FAIL make_1C actual=%h required=%h", bus.O_PS2_KEY, 11'h61C);
    else n_pass++;
    n_total++;
    if (err_cnt !== e0) $display("FAIL make_no_err actual=%0d required=%0d", err_cnt, e0);
    else n_pass++;
  endtask

  task automatic test_break();
    int u0;
    u0 = upd_cnt;
    send_byte(8'hF0);
    n_total++;
    if (upd_cnt !== u0) $display("FAIL break_prefix_upd actual=%0d required=%0d", upd_cnt, u0);
    else n_pass++;
    send_byte(8'h1C);
    n_total++;
    if (bus.O_PS2_KEY !== 11'h01C) $display("FAIL break_1C actual=%h required=%h", bus.O_PS2_KEY, 11'h01C);
    else n_pass++;
    n_total++;
    if (upd_cnt !== u0 + 1) $display("FAIL break_single_upd actual=%0d required=%0d", upd_cnt, u0 + 1);
    else n_pass++;
  endtask

  task automatic test_extended();
    send_byte(8'hE0);
    send_byte(8'h75);
    n_total++;
    if (bus.O_PS2_KEY !== 11'h775) $display("FAIL ext_make actual=%h required=%h", bus.O_PS2_KEY, 11'h775);
    else n_pass++;
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    n_total++;
    if (bus.O_PS2_KEY !== 11'h175) $display("FAIL ext_break actual=%h required=%h", bus.O_PS2_KEY, 11'h175);
    else n_pass++;
  endtask

  task automatic test_parity_err();
    int e0;
    e0 = err_cnt;
    send_frame(8'h29, 1'b1, 1'b1);
    n_total++;
    if (err_cnt !== e0 + 1) $display("FAIL parity_err_pulse actual=%0d required=%0d", err_cnt, e0 + 1);
    else n_pass++;
    n_total++;
    if (bus.O_PS2_KEY !== 11'h175) $display("FAIL parity_key_hold actual=%h required=%h", bus.O_PS2_KEY, 11'h175);
    else n_pass++;
    send_byte(8'h29);
    n_total++;
    if (bus.O_PS2_KEY !== 11'h629) $display("FAIL parity_recover actual=%h required=%h", bus.O_PS2_KEY, 11'h629);
    else n_pass++;
    // Stop bit low must also be rejected
    e0 = err_cnt;
    send_frame(8'h29, 1'b0, 1'b0);
    n_total++;
    if (err_cnt !== e0 + 1 || bus.O_PS2_KEY !== 11'h629)
      $display("FAIL stop_err actual=%0d/%h required=%0d/%h", err_cnt, bus.O_PS2_KEY, e0 + 1, 11'h629);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int e0;
    send_byte(8'hE0);
    e0 = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    bus.I_PS2_DAT = 1'b1;
    repeat (TO_CYC + 100) @(posedge clk);
    n_total++;
    if (err_cnt !== e0 + 1) $display("FAIL timeout_pulse actual=%0d required=%0d", err_cnt, e0 + 1);
    else n_pass++;
    send_byte(8'h6B);
    n_total++;
    if (bus.O_PS2_KEY !== 11'h26B) $display("FAIL timeout_ext_clr actual=%h required=%h", bus.O_PS2_KEY, 11'h26B);
    else n_pass++;
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    int u0;
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    u0 = upd_cnt;
    for (int i = 0; i < 8; i++) send_byte(seq[i]);
    n_total++;
    if (upd_cnt !== u0) $display("FAIL pause_no_upd actual=%0d required=%0d", upd_cnt, u0);
    else n_pass++;
    n_total++;
    if (bus.O_PS2_KEY !== 11'h26B) $display("FAIL pause_key_hold actual=%h required=%h", bus.O_PS2_KEY, 11'h26B);
    else n_pass++;
    send_byte(8'h16);
    n_total++;
    if (bus.O_PS2_KEY !== 11'h616) $display("FAIL pause_after actual=%h required=%h", bus.O_PS2_KEY, 11'h616);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    // Frames with no idle gap between the stop bit and the next start bit
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(1'(8'hE0 >> i));
    ps2_bit(~^8'hE0);
    ps2_bit(1'b1);
    send_byte(8'h1F);
    n_total++;
    if (bus.O_PS2_KEY !== 11'h31F) $display("FAIL b2b_key actual=%h required=%h", bus.O_PS2_KEY, 11'h31F);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    #2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (bus.O_PS2_KEY !== 11'h000) $display("FAIL midreset_key actual=%h required=%h", bus.O_PS2_KEY, 11'h000);
    else n_pass++;
    n_total++;
    if (bus.O_ERR !== 1'b0) $display("FAIL midreset_err actual=%b required=0", bus.O_ERR);
    else n_pass++;
    bus.I_PS2_DAT = 1'b1;
    bus.I_PS2_CLK = 1'b1;
    rst_n = 1'b1;
    repeat (2 * H) @(posedge clk);
    send_byte(8'h5A);
    n_total++;
    if (bus.O_PS2_KEY !== 11'h65A) $display("FAIL midreset_recover actual=%h required=%h", bus.O_PS2_KEY, 11'h65A);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    bus.I_PS2_CLK = 1'b1;
    bus.I_PS2_DAT = 1'b1;
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_parity_err();
    test_timeout();
    test_pause();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
